// File: rtl/csi2_px_packer.sv
// Packs PX_PER_WORD pixels per beat into one wide word for the CSI-2 TX packet builder.
// Optional macro CSI2_RAW10_BYTE_FMT_EN selects RAW10 wire byte order (PX_WIDTH=10, PX_PER_WORD=4 only).
module csi2_px_packer #(
  parameter int PX_WIDTH        = 10,
  parameter int PX_PER_WORD     = 4,
  parameter int IN_TDATA_WIDTH  = 16,
  parameter int OUT_TDATA_WIDTH = 40,
  parameter int TID_WIDTH       = 1,
  parameter int TDEST_WIDTH     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pkt_i_tvalid,
  output logic                         pkt_i_tready,
  input  logic [IN_TDATA_WIDTH-1:0]    pkt_i_tdata,
  input  logic                         pkt_i_tlast,
  input  logic                         pkt_i_tuser,
  output logic                         pkt_o_tvalid,
  input  logic                         pkt_o_tready,
  output logic [OUT_TDATA_WIDTH-1:0]   pkt_o_tdata,
  output logic [OUT_TDATA_WIDTH/8-1:0] pkt_o_tstrb,
  output logic [OUT_TDATA_WIDTH/8-1:0] pkt_o_tkeep,
  output logic                         pkt_o_tlast,
  output logic                         pkt_o_tuser,
  output logic [TID_WIDTH-1:0]         pkt_o_tid,
  output logic [TDEST_WIDTH-1:0]       pkt_o_tdest,
  output logic                         frame_start_o,
  output logic                         short_line_o
);

  localparam int CNT_W = (PX_PER_WORD > 1) ? $clog2(PX_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PX_PER_WORD - 1);

  logic [CNT_W-1:0]           cnt;
  logic [OUT_TDATA_WIDTH-1:0] acc;
  logic                       sof_pend;
  logic [OUT_TDATA_WIDTH-1:0] next_acc;
  logic [OUT_TDATA_WIDTH-1:0] word_fmt;
  logic                       accept;
  logic                       complete;
  logic                       unused_tdata;

  assign unused_tdata = ^{1'b0, pkt_i_tdata};

  assign pkt_o_tstrb = '1;
  assign pkt_o_tkeep = '1;
  assign pkt_o_tid   = '0;
  assign pkt_o_tdest = '0;

  assign pkt_i_tready = !pkt_o_tvalid || pkt_o_tready;
  assign accept       = pkt_i_tvalid && pkt_i_tready;
  assign complete     = accept && ((cnt == LAST_SLOT) || pkt_i_tlast);

  // Slots above cnt are still zero in acc, so a flushed short word is zero-padded for free.
  always_comb begin
    next_acc = acc;
    for (int i = 0; i < PX_PER_WORD; i++) begin
      if (cnt == CNT_W'(i)) begin
        next_acc[i*PX_WIDTH +: PX_WIDTH] = pkt_i_tdata[PX_WIDTH-1:0];
      end
    end
  end

`ifdef CSI2_RAW10_BYTE_FMT_EN
  // Byte 4 carries the four 2-bit LSB pairs, P3 in the top bits; bytes 0..3 are P0..P3 MSBs.
  assign word_fmt = {next_acc[31:30], next_acc[21:20], next_acc[11:10], next_acc[1:0],
                     next_acc[39:32], next_acc[29:22], next_acc[19:12], next_acc[9:2]};
`else
  assign word_fmt = next_acc;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      acc      <= '0;
      sof_pend <= 1'b0;
    end else if (accept) begin
      if (complete) begin
        cnt      <= '0;
        acc      <= '0;
        sof_pend <= 1'b0;
      end else begin
        cnt      <= cnt + 1'b1;
        acc      <= next_acc;
        sof_pend <= sof_pend | pkt_i_tuser;
      end
    end
  end

  // A load in the same cycle as a drain keeps tvalid high, giving bubble-free throughput.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_o_tvalid <= 1'b0;
      pkt_o_tdata  <= '0;
      pkt_o_tlast  <= 1'b0;
      pkt_o_tuser  <= 1'b0;
    end else if (complete) begin
      pkt_o_tvalid <= 1'b1;
      pkt_o_tdata  <= word_fmt;
      pkt_o_tlast  <= pkt_i_tlast;
      pkt_o_tuser  <= sof_pend | pkt_i_tuser;
    end else if (pkt_o_tready) begin
      pkt_o_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_start_o <= 1'b0;
      short_line_o  <= 1'b0;
    end else begin
      frame_start_o <= accept && pkt_i_tuser;
      short_line_o  <= accept && pkt_i_tlast && (cnt != LAST_SLOT);
    end
  end

endmodule

// File: tb/tb_csi2_px_packer.sv
// Directed testbench for csi2_px_packer; expected words follow the active byte format build.
module tb_csi2_px_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pkt_i_tvalid = 1'b0;
  logic        pkt_i_tready;
  logic [15:0] pkt_i_tdata = '0;
  logic        pkt_i_tlast = 1'b0;
  logic        pkt_i_tuser = 1'b0;
  logic        pkt_o_tvalid;
  logic        pkt_o_tready = 1'b1;
  logic [39:0] pkt_o_tdata;
  logic [4:0]  pkt_o_tstrb;
  logic [4:0]  pkt_o_tkeep;
  logic        pkt_o_tlast;
  logic        pkt_o_tuser;
  logic [0:0]  pkt_o_tid;
  logic [0:0]  pkt_o_tdest;
  logic        frame_start_o;
  logic        short_line_o;

  int checks = 0;
  int passed = 0;
  logic [41:0] outq[$];
  int fs_cnt = 0, sl_cnt = 0, stall_err = 0, in_stall = 0, acc_px = 0;
  logic prev_stalled = 1'b0;
  logic [42:0] prev_out;
  logic rand_bp = 1'b0;

  csi2_px_packer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pkt_i_tvalid(pkt_i_tvalid), .pkt_i_tready(pkt_i_tready), .pkt_i_tdata(pkt_i_tdata),
    .pkt_i_tlast(pkt_i_tlast), .pkt_i_tuser(pkt_i_tuser),
    .pkt_o_tvalid(pkt_o_tvalid), .pkt_o_tready(pkt_o_tready), .pkt_o_tdata(pkt_o_tdata),
    .pkt_o_tstrb(pkt_o_tstrb), .pkt_o_tkeep(pkt_o_tkeep), .pkt_o_tlast(pkt_o_tlast),
    .pkt_o_tuser(pkt_o_tuser), .pkt_o_tid(pkt_o_tid), .pkt_o_tdest(pkt_o_tdest),
    .frame_start_o(frame_start_o), .short_line_o(short_line_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change at posedge+1, so the negedge view is what the next posedge will act on.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled && {pkt_o_tvalid, pkt_o_tlast, pkt_o_tuser, pkt_o_tdata} !== prev_out)
        stall_err++;
      if (pkt_o_tvalid && !pkt_o_tready && pkt_i_tready) stall_err++;
      if (pkt_o_tvalid && pkt_o_tready) outq.push_back({pkt_o_tlast, pkt_o_tuser, pkt_o_tdata});
      prev_stalled = pkt_o_tvalid && !pkt_o_tready;
      prev_out = {pkt_o_tvalid, pkt_o_tlast, pkt_o_tuser, pkt_o_tdata};
      if (frame_start_o) fs_cnt++;
      if (short_line_o) sl_cnt++;
      if (pkt_i_tvalid && !pkt_i_tready) in_stall++;
      if (pkt_i_tvalid && pkt_i_tready) acc_px++;
    end
  end

  always @(posedge clk_i) begin
    if (rand_bp) begin
      #1;
      pkt_o_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

  function automatic logic [39:0] fmt_word(input logic [39:0] raw);
    logic [39:0] w;
    logic [9:0]  p;
`ifdef CSI2_RAW10_BYTE_FMT_EN
    w = '0;
    for (int i = 0; i < 4; i++) begin
      p = raw[i*10 +: 10];
      w[i*8 +: 8]     = p[9:2];
      w[32 + 2*i +: 2] = p[1:0];
    end
`else
    p = '0;
    w = raw;
`endif
    return w;
  endfunction

  task automatic send_px(input logic [15:0] d, input logic u, input logic l);
    pkt_i_tvalid = 1'b1;
    pkt_i_tdata  = d;
    pkt_i_tuser  = u;
    pkt_i_tlast  = l;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk_i);
      if (pkt_i_tready) begin
        @(posedge clk_i); #1;
        pkt_i_tvalid = 1'b0;
        pkt_i_tuser  = 1'b0;
        pkt_i_tlast  = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    checks++;
    $display("[TB] FAIL send_px: pixel %h not accepted, tready=%b required 1", d, pkt_i_tready);
    pkt_i_tvalid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int w = 0; w < 300; w++) begin
      if (outq.size() >= n) return;
      @(posedge clk_i); #1;
    end
    checks++;
    $display("[TB] FAIL wait_words: got %0d words, required %0d", outq.size(), n);
  endtask

  task automatic test_reset;
    logic [49:0] got;
    repeat (2) @(posedge clk_i);
    #1;
    got = {pkt_o_tvalid, pkt_o_tlast, pkt_o_tuser, pkt_o_tdata, frame_start_o, short_line_o,
           pkt_o_tid, pkt_o_tdest, pkt_i_tready};
    checks++;
    if (got !== 50'h1) $display("[TB] FAIL reset_outputs: got %h, required %h", got, 50'h1);
    else passed++;
    checks++;
    if ({pkt_o_tstrb, pkt_o_tkeep} !== 10'h3FF)
      $display("[TB] FAIL const_strb_keep: got %h, required 3ff", {pkt_o_tstrb, pkt_o_tkeep});
    else passed++;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single_word;
    logic [41:0] w;
    logic [41:0] exp;
    int sl0;
    outq.delete();
    pkt_o_tready = 1'b1;
    sl0 = sl_cnt;
    send_px(16'h001, 0, 0);
    send_px(16'h002, 0, 0);
    send_px(16'h003, 0, 0);
    send_px(16'h3FF, 0, 1);
    wait_words(1);
    w = (outq.size() > 0) ? outq.pop_front() : '0;
    exp = {1'b1, 1'b0, fmt_word({10'h3FF, 10'h003, 10'h002, 10'h001})};
    checks++;
    if (w !== exp) $display("[TB] FAIL single_word: got %h, required %h", w, exp);
    else passed++;
    checks++;
    if (sl_cnt - sl0 !== 0) $display("[TB] FAIL full_line_no_short: got %0d pulses, required 0", sl_cnt - sl0);
    else passed++;
  endtask

  task automatic test_sof;
    logic [41:0] w1, w2, w3;
    int fs0;
    outq.delete();
    fs0 = fs_cnt;
    for (int i = 0; i < 8; i++) send_px(16'h100 + 16'(i), i == 0, i == 7);
    wait_words(2);
    w1 = (outq.size() > 0) ? outq.pop_front() : '0;
    w2 = (outq.size() > 0) ? outq.pop_front() : '0;
    checks++;
    if (w1 !== {1'b0, 1'b1, fmt_word({10'h103, 10'h102, 10'h101, 10'h100})})
      $display("[TB] FAIL sof_word1: got %h, required %h", w1,
               {1'b0, 1'b1, fmt_word({10'h103, 10'h102, 10'h101, 10'h100})});
    else passed++;
    checks++;
    if (w2 !== {1'b1, 1'b0, fmt_word({10'h107, 10'h106, 10'h105, 10'h104})})
      $display("[TB] FAIL sof_word2: got %h, required %h", w2,
               {1'b1, 1'b0, fmt_word({10'h107, 10'h106, 10'h105, 10'h104})});
    else passed++;
    checks++;
    if (fs_cnt - fs0 !== 1) $display("[TB] FAIL frame_start_once: got %0d pulses, required 1", fs_cnt - fs0);
    else passed++;
    // SOF on slot 2 still marks the word being built
    send_px(16'h200, 0, 0);
    send_px(16'h201, 0, 0);
    send_px(16'h202, 1, 0);
    send_px(16'h203, 0, 1);
    wait_words(1);
    w3 = (outq.size() > 0) ? outq.pop_front() : '0;
    checks++;
    if (w3 !== {1'b1, 1'b1, fmt_word({10'h203, 10'h202, 10'h201, 10'h200})})
      $display("[TB] FAIL sof_mid_word: got %h, required %h", w3,
               {1'b1, 1'b1, fmt_word({10'h203, 10'h202, 10'h201, 10'h200})});
    else passed++;
    checks++;
    if (fs_cnt - fs0 !== 2) $display("[TB] FAIL frame_start_mid: got %0d pulses, required 2", fs_cnt - fs0);
    else passed++;
  endtask

  task automatic test_short_line;
    logic [41:0] w1, w2;
    int sl0;
    outq.delete();
    sl0 = sl_cnt;
    for (int i = 0; i < 6; i++) send_px(16'h011 + 16'(i), 0, i == 5);
    wait_words(2);
    @(posedge clk_i); #1;
    w1 = (outq.size() > 0) ? outq.pop_front() : '0;
    w2 = (outq.size() > 0) ? outq.pop_front() : '0;
    checks++;
    if (w1 !== {2'b00, fmt_word({10'h014, 10'h013, 10'h012, 10'h011})})
      $display("[TB] FAIL short_word1: got %h, required %h", w1,
               {2'b00, fmt_word({10'h014, 10'h013, 10'h012, 10'h011})});
    else passed++;
    checks++;
    if (w2 !== {2'b10, fmt_word({10'h000, 10'h000, 10'h016, 10'h015})})
      $display("[TB] FAIL short_word2: got %h, required %h", w2,
               {2'b10, fmt_word({10'h000, 10'h000, 10'h016, 10'h015})});
    else passed++;
    checks++;
    if (sl_cnt - sl0 !== 1) $display("[TB] FAIL short_line_pulse: got %0d pulses, required 1", sl_cnt - sl0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [41:0] w1, w2;
    int st0;
    outq.delete();
    pkt_o_tready = 1'b1;
    st0 = in_stall;
    for (int i = 0; i < 8; i++) send_px(16'hFC00 | 16'(10'h2A0 + i), 0, 0);
    wait_words(2);
    w1 = (outq.size() > 0) ? outq.pop_front() : '0;
    w2 = (outq.size() > 0) ? outq.pop_front() : '0;
    checks++;
    if (in_stall - st0 !== 0) $display("[TB] FAIL b2b_no_stall: got %0d stall cycles, required 0", in_stall - st0);
    else passed++;
    checks++;
    if ({w1, w2} !== {2'b00, fmt_word({10'h2A3, 10'h2A2, 10'h2A1, 10'h2A0}),
                      2'b00, fmt_word({10'h2A7, 10'h2A6, 10'h2A5, 10'h2A4})})
      $display("[TB] FAIL b2b_words: got %h %h, required %h %h", w1, w2,
               {2'b00, fmt_word({10'h2A3, 10'h2A2, 10'h2A1, 10'h2A0})},
               {2'b00, fmt_word({10'h2A7, 10'h2A6, 10'h2A5, 10'h2A4})});
    else passed++;
  endtask

  task automatic test_backpressure;
    logic [41:0] expq[$];
    logic [39:0] raw;
    logic [9:0]  pix;
    logic [41:0] got;
    int bad, px0, lasts;
    outq.delete();
    stall_err = 0;
    px0 = acc_px;
    raw = '0;
    rand_bp = 1'b1;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 1920; i++) begin
        pix = 10'((i * 37 + ln * 101 + 5) & 32'h3FF);
        raw[(i % 4)*10 +: 10] = pix;
        if (i % 4 == 3) expq.push_back({i == 1919, i == 3, fmt_word(raw)});
        send_px({6'h2B, pix}, i == 0, i == 1919);
      end
    end
    rand_bp = 1'b0;
    @(posedge clk_i); #1;
    pkt_o_tready = 1'b1;
    wait_words(960);
    checks++;
    if (outq.size() !== 960) $display("[TB] FAIL bp_word_count: got %0d, required 960", outq.size());
    else passed++;
    bad = 0;
    lasts = 0;
    for (int k = 0; k < 960 && k < outq.size(); k++) begin
      got = outq[k];
      if (got[41]) lasts++;
      if (got !== expq[k]) begin
        if (bad < 3) $display("[TB] word %0d: got %h, required %h", k, got, expq[k]);
        bad++;
      end
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL bp_word_data: got %0d bad words, required 0", bad);
    else passed++;
    checks++;
    if (lasts !== 2) $display("[TB] FAIL bp_tlast_count: got %0d, required 2", lasts);
    else passed++;
    checks++;
    if (stall_err !== 0) $display("[TB] FAIL bp_stable: got %0d stall violations, required 0", stall_err);
    else passed++;
    checks++;
    if (acc_px - px0 !== 3840) $display("[TB] FAIL bp_px_accepted: got %0d, required 3840", acc_px - px0);
    else passed++;
  endtask

  task automatic test_reset_mid_line;
    logic [42:0] got;
    logic [41:0] w;
    // Pending output word held by backpressure must vanish on reset
    pkt_o_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_px(16'h300 + 16'(i), 0, 0);
    @(posedge clk_i); #1;
    checks++;
    if (pkt_o_tvalid !== 1'b1) $display("[TB] FAIL rst_pending_setup: got tvalid %b, required 1", pkt_o_tvalid);
    else passed++;
    #2 rst_i = 1'b1;
    #1;
    got = {pkt_o_tvalid, pkt_o_tlast, pkt_o_tuser, pkt_o_tdata};
    checks++;
    if (got !== '0) $display("[TB] FAIL rst_pending_drop: got %h, required 0", got);
    else passed++;
    @(negedge clk_i);
    rst_i = 1'b0;
    pkt_o_tready = 1'b1;
    @(posedge clk_i); #1;
    outq.delete();
    send_px(16'h3AA, 1, 0);
    send_px(16'h3BB, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    got = {pkt_o_tvalid, pkt_o_tlast, pkt_o_tuser, pkt_o_tdata};
    checks++;
    if ({got, frame_start_o, short_line_o, pkt_i_tready} !== 46'h1)
      $display("[TB] FAIL rst_mid_outputs: got %h, required %h",
               {got, frame_start_o, short_line_o, pkt_i_tready}, 46'h1);
    else passed++;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    outq.delete();
    for (int i = 0; i < 4; i++) send_px(16'h021 + 16'(i), 0, i == 3);
    wait_words(1);
    w = (outq.size() > 0) ? outq.pop_front() : '0;
    checks++;
    if (w !== {2'b10, fmt_word({10'h024, 10'h023, 10'h022, 10'h021})})
      $display("[TB] FAIL rst_first_word: got %h, required %h", w,
               {2'b10, fmt_word({10'h024, 10'h023, 10'h022, 10'h021})});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_sof();
    test_short_line();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
